ysyx_22050039_key_lut_pipe: RTL and testbench
=============================================

YSYX_22050039_KEY_LUT_PIPE -- requirements
Module: ysyx_22050039_key_lut_pipe

Interface
REQ-001 SHALL have parameter NR_KEY, default 4: number of table entries, range 2..64.
REQ-002 SHALL have parameter KEY_LEN, default 4: key width.
REQ-003 SHALL have parameter DATA_LEN, default 32: data width.
REQ-004 SHALL have parameter HAS_DEFAULT, default 0: 1 means a miss returns default_out, 0 means a miss returns zero.
REQ-005 SHALL have derived localparam IDX_LEN equal to max(1, clog2(NR_KEY)).
REQ-006 SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-008 SHALL have port wr_en, input, 1 bit: table entry write strobe.
REQ-009 SHALL have port wr_idx, input, IDX_LEN bits: entry index to write.
REQ-010 SHALL have port wr_key, input, KEY_LEN bits: key to store.
REQ-011 SHALL have port wr_data, input, DATA_LEN bits: data to store.
REQ-012 SHALL have port wr_inv, input, 1 bit: when set with wr_en, invalidate the entry instead of writing it.
REQ-013 SHALL have port in_valid, input, 1 bit: lookup request valid.
REQ-014 SHALL have port in_ready, output, 1 bit: lookup request accepted.
REQ-015 SHALL have port in_key, input, KEY_LEN bits: lookup key.
REQ-016 SHALL have port default_out, input, DATA_LEN bits: miss value, sampled with the request.
REQ-017 SHALL have port out_valid, output, 1 bit: result valid.
REQ-018 SHALL have port out_ready, input, 1 bit: consumer accepts result.
REQ-019 SHALL have port out_data, output, DATA_LEN bits: lookup result.
REQ-020 SHALL have port out_hit, output, 1 bit: key matched a valid entry.
REQ-021 SHALL have port out_idx, output, IDX_LEN bits: index of the matching entry, 0 on miss.

Function
REQ-022 SHALL hold NR_KEY entries, each holding {valid, key, data}, in registers.
REQ-023 SHALL write entry wr_idx on a clock edge with wr_en=1 and wr_inv=0: valid=1, key=wr_key, data=wr_data.
REQ-024 SHALL clear only the valid bit of entry wr_idx on a clock edge with wr_en=1 and wr_inv=1.
REQ-025 SHALL ignore writes with wr_idx >= NR_KEY, leaving the table unchanged.
REQ-026 SHALL accept a request ("fire") when in_valid and in_ready are both 1 on a clock edge.
REQ-027 SHALL drive in_ready = !out_valid || out_ready, giving a one-deep pipeline with full throughput under continuous out_ready.
REQ-028 SHALL count a match only when the entry is valid and its key equals in_key.
REQ-029 SHALL, on multiple matches, select the lowest index only; data SHALL NOT be OR-merged.
REQ-030 SHALL register a lookup result on fire, giving fixed latency 1: result visible the cycle after acceptance.
REQ-031 SHALL register the following on a hit: out_data=entry data, out_hit=1, out_idx=matching index.
REQ-032 SHALL register the following on a miss: out_hit=0, out_idx=0, and out_data=default_out if HAS_DEFAULT=1, otherwise 0.
REQ-033 SHALL, on a write and a fire in the same cycle, look up against pre-write table contents; the write is visible from the next cycle.
REQ-034 SHALL update out_valid as follows: set on fire; cleared when out_valid && out_ready && !fire; unchanged otherwise.
REQ-035 SHALL hold out_data, out_hit and out_idx stable while out_valid=1 and out_ready=0, regardless of in_key or table writes.
REQ-036 SHALL let table writes proceed independently of the handshake, never stalled by it.
REQ-037 SHALL compute in_ready combinationally from out_valid and out_ready only; in_ready SHALL NOT depend on in_valid.

Reset
REQ-038 SHALL, while rst=1 on a clock edge, clear all entry valid bits, and set out_valid=0, out_data=0, out_hit=0, out_idx=0.
REQ-039 SHALL give rst priority over simultaneous wr_en and fire; both are dropped.
REQ-040 SHALL make an in-flight result asserted during reset lost, with out_valid=0 the cycle after reset.
REQ-041 SHALL leave entry key and data fields unspecified after reset; they are unobservable because valid=0.

Verification
REQ-042 SHALL cover: write idx2 = {key 0x5, data 0xDEADBEEF}, then look up 0x5 -> next cycle out_valid=1, out_hit=1, out_idx=2, out_data=0xDEADBEEF.
REQ-043 SHALL cover: entries idx1 and idx3 both keyed 0xA with data 0x11 and 0x33, then look up 0xA -> out_idx=1, out_data=0x11.
REQ-044 SHALL cover: HAS_DEFAULT=1, look up unmapped key 0x7 with default_out=0xCAFE -> out_hit=0, out_idx=0, out_data=0xCAFE; the same case with HAS_DEFAULT=0 -> out_data=0.
REQ-045 SHALL cover: out_ready held 0 for 3 cycles with result valid -> in_ready=0, output stable, and a new in_key is not accepted; release -> back-to-back results, one per cycle.
REQ-046 SHALL cover: same-cycle write idx0 = {0x3, 0x99} and lookup of 0x3 -> miss; the repeated lookup -> hit with 0x99; invalidate idx0, then look up -> miss.
REQ-047 SHALL cover: rst pulse with out_valid=1 -> out_valid=0, and a following lookup of any previously written key -> miss.

Source files
------------

// File: rtl/ysyx_22050039_key_lut_pipe.sv
// Register-based key/data lookup table with one-deep registered result stage.
// Lookups arbitrate to the lowest matching index; table writes never stall.
module ysyx_22050039_key_lut_pipe #(
  parameter int NR_KEY      = 4,
  parameter int KEY_LEN     = 4,
  parameter int DATA_LEN    = 32,
  parameter int HAS_DEFAULT = 0,
  localparam int IDX_LEN    = (NR_KEY > 1) ? $clog2(NR_KEY) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [IDX_LEN-1:0]  wr_idx,
  input  logic [KEY_LEN-1:0]  wr_key,
  input  logic [DATA_LEN-1:0] wr_data,
  input  logic                wr_inv,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [KEY_LEN-1:0]  in_key,
  input  logic [DATA_LEN-1:0] default_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] out_data,
  output logic                out_hit,
  output logic [IDX_LEN-1:0]  out_idx
);

  // Handshake: a request fires on a rising edge when in_valid && in_ready;
  // a result is consumed when out_valid && out_ready. in_ready depends only
  // on the output stage, never on in_valid.

  logic                valid_q [NR_KEY];
  logic [KEY_LEN-1:0]  key_q   [NR_KEY];
  logic [DATA_LEN-1:0] data_q  [NR_KEY];

  logic                out_valid_q, out_valid_d;
  logic [DATA_LEN-1:0] out_data_q, out_data_d;
  logic                out_hit_q, out_hit_d;
  logic [IDX_LEN-1:0]  out_idx_q, out_idx_d;

  logic                fire;
  logic                lk_hit;
  logic [IDX_LEN-1:0]  lk_idx;
  logic [DATA_LEN-1:0] lk_data;

  assign in_ready = !out_valid_q || out_ready;
  assign fire     = in_valid && in_ready;

  // Ascending scan with a found flag so the lowest matching index wins.
  always_comb begin
    lk_hit  = 1'b0;
    lk_idx  = '0;
    lk_data = (HAS_DEFAULT != 0) ? default_out : '0;
    for (int i = 0; i < NR_KEY; i++) begin
      if (!lk_hit && valid_q[i] && (key_q[i] == in_key)) begin
        lk_hit  = 1'b1;
        lk_idx  = IDX_LEN'(i);
        lk_data = data_q[i];
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_hit_d   = out_hit_q;
    out_idx_d   = out_idx_q;
    if (fire) begin
      out_valid_d = 1'b1;
      out_data_d  = lk_data;
      out_hit_d   = lk_hit;
      out_idx_d   = lk_idx;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Indices at or above NR_KEY never match the loop and are dropped.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NR_KEY; i++) begin
      if (rst) begin
        valid_q[i] <= 1'b0;
      end else if (wr_en && (wr_idx == IDX_LEN'(i))) begin
        valid_q[i] <= !wr_inv;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NR_KEY; i++) begin
      if (!rst && wr_en && !wr_inv && (wr_idx == IDX_LEN'(i))) begin
        key_q[i]  <= wr_key;
        data_q[i] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_hit_q   <= 1'b0;
      out_idx_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_hit_q   <= out_hit_d;
      out_idx_q   <= out_idx_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_hit   = out_hit_q;
  assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_ysyx_22050039_key_lut_pipe.sv
// Directed bench for the key lookup table: two instances (miss returns zero /
// miss returns default_out) share all inputs so their tables stay identical.
module tb_ysyx_22050039_key_lut_pipe;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [1:0]  wr_idx;
  logic [3:0]  wr_key;
  logic [31:0] wr_data;
  logic        wr_inv;
  logic        in_valid;
  logic [3:0]  in_key;
  logic [31:0] default_out;
  logic        out_ready;

  logic        in_ready,  in_ready_d;
  logic        out_valid, out_valid_d;
  logic [31:0] out_data,  out_data_d;
  logic        out_hit,   out_hit_d;
  logic [1:0]  out_idx,   out_idx_d;

  int total;
  int bad;

  ysyx_22050039_key_lut_pipe #(
    .NR_KEY(4), .KEY_LEN(4), .DATA_LEN(32), .HAS_DEFAULT(0)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key),
    .wr_data(wr_data), .wr_inv(wr_inv), .in_valid(in_valid), .in_ready(in_ready),
    .in_key(in_key), .default_out(default_out), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_hit(out_hit), .out_idx(out_idx)
  );

  ysyx_22050039_key_lut_pipe #(
    .NR_KEY(4), .KEY_LEN(4), .DATA_LEN(32), .HAS_DEFAULT(1)
  ) dut_dflt (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key),
    .wr_data(wr_data), .wr_inv(wr_inv), .in_valid(in_valid), .in_ready(in_ready_d),
    .in_key(in_key), .default_out(default_out), .out_valid(out_valid_d),
    .out_ready(out_ready), .out_data(out_data_d), .out_hit(out_hit_d), .out_idx(out_idx_d)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input logic [1:0] idx, input logic [3:0] key,
                          input logic [31:0] data, input logic inv);
    wr_en   = 1'b1;
    wr_idx  = idx;
    wr_key  = key;
    wr_data = data;
    wr_inv  = inv;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic hit,
                         input logic [1:0] idx, input logic [31:0] data);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".hit"},   32'(out_hit),   32'(hit));
    chk({tag, ".idx"},   32'(out_idx),   32'(idx));
    chk({tag, ".data"},  out_data,       data);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_key = '0; wr_data = '0; wr_inv = 1'b0;
    in_valid = 1'b0; in_key = '0; default_out = 32'hCAFE; out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk_out("reset", 1'b0, 1'b0, 2'd0, 32'h0);
    chk("reset.in_ready", 32'(in_ready), 32'd1);

    // single write then hit
    drive_wr(2'd2, 4'h5, 32'hDEADBEEF, 1'b0);
    step();
    wr_en = 1'b0;
    in_valid = 1'b1; in_key = 4'h5;
    step();
    in_valid = 1'b0;
    chk_out("hit2", 1'b1, 1'b1, 2'd2, 32'hDEADBEEF);
    step();
    chk("drain.valid", 32'(out_valid), 32'd0);

    // two entries share a key: lowest index wins, no OR-merge
    drive_wr(2'd1, 4'hA, 32'h11, 1'b0);
    step();
    drive_wr(2'd3, 4'hA, 32'h33, 1'b0);
    step();
    wr_en = 1'b0;
    in_valid = 1'b1; in_key = 4'hA;
    step();
    in_valid = 1'b0;
    chk_out("multi", 1'b1, 1'b1, 2'd1, 32'h11);

    // miss: zero vs default_out
    in_valid = 1'b1; in_key = 4'h7; default_out = 32'hCAFE;
    step();
    in_valid = 1'b0;
    chk_out("miss0", 1'b1, 1'b0, 2'd0, 32'h0);
    chk("miss_dflt.hit",  32'(out_hit_d), 32'd0);
    chk("miss_dflt.idx",  32'(out_idx_d), 32'd0);
    chk("miss_dflt.data", out_data_d,     32'hCAFE);
    step();

    // backpressure: result held for 3 cycles despite key change and a write
    out_ready = 1'b0;
    in_valid = 1'b1; in_key = 4'h5;
    step();
    in_key = 4'hA;
    drive_wr(2'd0, 4'h5, 32'h55, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      wr_en = 1'b0;
      chk("stall.in_ready", 32'(in_ready), 32'd0);
      chk_out("stall", 1'b1, 1'b1, 2'd2, 32'hDEADBEEF);
    end
    out_ready = 1'b1;
    #1;
    chk("release.in_ready", 32'(in_ready), 32'd1);
    step();
    in_key = 4'h5;
    chk_out("b2b0", 1'b1, 1'b1, 2'd1, 32'h11);
    step();
    in_valid = 1'b0;
    chk_out("b2b1", 1'b1, 1'b1, 2'd0, 32'h55);
    step();
    chk("b2b.drain", 32'(out_valid), 32'd0);

    // same-cycle write and lookup sees the old table
    drive_wr(2'd0, 4'h3, 32'h99, 1'b0);
    in_valid = 1'b1; in_key = 4'h3;
    step();
    wr_en = 1'b0;
    chk_out("wr_same", 1'b1, 1'b0, 2'd0, 32'h0);
    chk("wr_same_dflt.data", out_data_d, 32'hCAFE);
    step();
    in_valid = 1'b0;
    chk_out("wr_next", 1'b1, 1'b1, 2'd0, 32'h99);
    drive_wr(2'd0, 4'h0, 32'h0, 1'b1);
    step();
    wr_en = 1'b0; wr_inv = 1'b0;
    in_valid = 1'b1; in_key = 4'h3;
    step();
    in_valid = 1'b0;
    chk_out("inval", 1'b1, 1'b0, 2'd0, 32'h0);
    // invalidate must not touch the other entries
    in_valid = 1'b1; in_key = 4'hA;
    step();
    in_valid = 1'b0;
    chk_out("inval_keep", 1'b1, 1'b1, 2'd1, 32'h11);

    // reset with a result in flight and a simultaneous write + request
    out_ready = 1'b0;
    in_valid = 1'b1; in_key = 4'hA;
    step();
    chk("pre_rst.valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    drive_wr(2'd2, 4'h7, 32'h70, 1'b0);
    step();
    rst = 1'b0; wr_en = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk_out("rst", 1'b0, 1'b0, 2'd0, 32'h0);
    in_valid = 1'b1; in_key = 4'hA;
    step();
    in_key = 4'h5;
    chk_out("rst_missA", 1'b1, 1'b0, 2'd0, 32'h0);
    step();
    in_key = 4'h7;
    chk_out("rst_miss5", 1'b1, 1'b0, 2'd0, 32'h0);
    step();
    in_valid = 1'b0;
    chk_out("rst_miss7", 1'b1, 1'b0, 2'd0, 32'h0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
